alu_issue: RTL and testbench
============================

Name: alu_issue

Overview:
Issue stage that drives the ALU's operand/operation interface. Decodes a fetched RV32I instruction into alu_op, left/right operands, destination and control flags. Registers them into a single ID/EX pipeline slot with valid/ready handshake, stall and flush. Sits between register-file read and the execute stage; its outputs feed the ALU operand and op inputs directly.

Parameters:
CNT_W, 16, width of the issued-instruction and illegal-instruction counters

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  instruction/operand bundle valid
in_ready  out  1  slot can accept a bundle this cycle
instr  in  32  raw instruction word
pc  in  32  instruction address
rs1_data  in  32  register-file read data for rs1
rs2_data  in  32  register-file read data for rs2
flush  in  1  squash slot contents (branch taken / redirect)
out_valid  out  1  registered bundle valid toward execute
out_ready  in  1  execute consumes bundle this cycle
left_operand  out  32  ALU left operand
right_operand  out  32  ALU right operand
alu_op  out  alu_op_t  ALU_AND / ALU_OR / ALU_ADD / ALU_SUB
imm  out  32  sign-extended immediate (branch offset, store data path unused)
store_data  out  32  rs2_data passed through for stores
rd  out  5  destination register
reg_write  out  1  write rd on completion
is_branch  out  1  BEQ: execute takes branch when ALU zero flag set
is_load / is_store  out  1 each  memory access, address = ALU result
illegal  out  1  unsupported encoding
issued_cnt  out  CNT_W  bundles handed to execute (out_valid & out_ready)
illegal_cnt  out  CNT_W  illegal bundles handed to execute

Behaviour:
- Reset (async, rst_n=0): out_valid=0, all data outputs 0, alu_op=ALU_ADD, flags 0, both counters 0. in_ready=1 immediately after reset release.
- Handshake: in_ready = !out_valid | out_ready (combinational). Accept when in_valid & in_ready; bundle appears on outputs next cycle with out_valid=1 (latency 1).
- Stall: out_valid & !out_ready -> all outputs held stable, in_ready=0; in_valid ignored.
- Simultaneous consume and accept: slot replaced in same edge, out_valid stays 1 (full throughput).
- Consume without accept: out_valid -> 0, data outputs hold last value.
- flush: highest priority; next cycle out_valid=0, any bundle accepted in the same cycle is dropped; counters not incremented for a flushed slot. A handshake completing in the flush cycle still counts.
- Decode (opcode[6:0]):
  R 0110011: f3=000 f7=0000000 ADD, f7=0100000 SUB; f3=111 AND; f3=110 OR (f7=0); left=rs1, right=rs2, reg_write=1.
  I 0010011: f3 000/111/110 -> ADD/AND/OR; right=sext(instr[31:20]); reg_write=1.
  Load 0000011 f3=010: ADD rs1+I-imm, is_load, reg_write=1. Store 0100011 f3=010: ADD rs1+S-imm, is_store, store_data=rs2.
  Branch 1100011 f3=000: SUB rs1-rs2, is_branch, imm=B-imm; reg_write=0.
  LUI 0110111: left=0, right=U-imm, ADD. AUIPC 0010111: left=pc, right=U-imm, ADD.
  Anything else: illegal=1, alu_op=ADD, reg_write/is_*=0, operands 0.
- rd forced to 0 reg_write=0 when rd field is x0.
- Counters wrap modulo 2^CNT_W.

Decomposition:
- common_pkg: opcode localparams, funct3/funct7 constants, decoded-bundle struct (op, operands, imm, rd, flags); alu_op_t unchanged.
- Sub-module alu_ctrl_decode: pure combinational instr/pc/rs data -> bundle struct; alu_issue holds slot register, handshake, counters.

Test Plan:
- Reset mid-stream (rst_n low while out_valid=1) -> out_valid=0, counters 0 asynchronously, in_ready=1 after release.
- instr=0x002081B3, rs1=5, rs2=3 -> next cycle ALU_ADD, left=5, right=3, rd=3, reg_write=1; instr=0x402081B3 -> ALU_SUB.
- instr=0xFFF00293 -> ALU_ADD, left=0 (rs1_data=0), right=0xFFFFFFFF, rd=5; instr=0x123453B7 -> left=0, right=0x12345000, rd=7.
- instr=0x00208463 -> ALU_SUB, is_branch=1, imm=8, reg_write=0; instr=0x00000000 -> illegal=1, illegal_cnt+1 on consume.
- out_ready=0 for 3 cycles with in_valid=1 -> outputs stable, in_ready=0; then out_ready=1 with in_valid=1 -> back-to-back transfer, issued_cnt +1 per cycle.
- flush together with accept -> out_valid=0 next cycle, issued_cnt unchanged; CNT_W=4, 17 issues -> issued_cnt=1.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared types for the ALU issue stage: ALU operation encoding, RV32I opcode
// and funct constants, the decoded bundle that travels from decode into the
// ID/EX slot, and small helpers that assemble the RV32I immediates.
package alu_issue_pkg;

  typedef enum logic [1:0] {
    ALU_AND = 2'd0,
    ALU_OR  = 2'd1,
    ALU_ADD = 2'd2,
    ALU_SUB = 2'd3
  } alu_op_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Everything execute needs for one instruction.
  typedef struct packed {
    alu_op_t     op;
    logic [31:0] left;
    logic [31:0] right;
    logic [31:0] imm;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        reg_write;
    logic        is_branch;
    logic        is_load;
    logic        is_store;
    logic        illegal;
  } issue_bundle_t;

  // Bundle value seen after reset and used as the base for every decode.
  localparam issue_bundle_t BUNDLE_RESET = '{
    op:         ALU_ADD,
    left:       32'd0,
    right:      32'd0,
    imm:        32'd0,
    store_data: 32'd0,
    rd:         5'd0,
    reg_write:  1'b0,
    is_branch:  1'b0,
    is_load:    1'b0,
    is_store:   1'b0,
    illegal:    1'b0
  };

  // I-type immediate from instr[31:20].
  function automatic logic [31:0] imm_i(input logic [11:0] field);
    return {{20{field[11]}}, field};
  endfunction

  // S-type immediate from instr[31:25] and instr[11:7].
  function automatic logic [31:0] imm_s(input logic [6:0] hi, input logic [4:0] lo);
    return {{20{hi[6]}}, hi, lo};
  endfunction

  // B-type immediate from the same two fields, reshuffled and scaled by 2.
  function automatic logic [31:0] imm_b(input logic [6:0] hi, input logic [4:0] lo);
    return {{19{hi[6]}}, hi[6], lo[0], hi[5:0], lo[4:1], 1'b0};
  endfunction

  // U-type immediate from instr[31:12].
  function automatic logic [31:0] imm_u(input logic [19:0] field);
    return {field, 12'd0};
  endfunction

endpackage

// File: rtl/alu_issue_alu_ctrl_decode.sv
// Purely combinational RV32I subset decoder: turns a fetched instruction plus
// its register-file read data into the bundle handed to the ALU.  Anything
// outside the supported subset comes out as an illegal bundle with zeroed
// operands so execute never acts on garbage.
module alu_ctrl_decode
  import alu_issue_pkg::*;
(
  input  logic [31:0]   instr_i,
  input  logic [31:0]   pc_i,
  input  logic [31:0]   rs1_data_i,
  input  logic [31:0]   rs2_data_i,
  output issue_bundle_t bundle_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd_field;
  logic       legal;
  logic       writes_rd;

  assign opcode   = instr_i[6:0];
  assign funct3   = instr_i[14:12];
  assign funct7   = instr_i[31:25];
  assign rd_field = instr_i[11:7];

  // Select op, operands and flags per opcode, then apply illegal and x0 rules.
  always_comb begin
    bundle_o  = BUNDLE_RESET;
    legal     = 1'b1;
    writes_rd = 1'b0;

    case (opcode)
      OPC_OP: begin
        bundle_o.left  = rs1_data_i;
        bundle_o.right = rs2_data_i;
        writes_rd      = 1'b1;
        if (funct3 == F3_ADD && funct7 == F7_BASE) begin
          bundle_o.op = ALU_ADD;
        end else if (funct3 == F3_ADD && funct7 == F7_ALT) begin
          bundle_o.op = ALU_SUB;
        end else if (funct3 == F3_AND && funct7 == F7_BASE) begin
          bundle_o.op = ALU_AND;
        end else if (funct3 == F3_OR && funct7 == F7_BASE) begin
          bundle_o.op = ALU_OR;
        end else begin
          legal = 1'b0;
        end
      end

      OPC_OP_IMM: begin
        bundle_o.left  = rs1_data_i;
        bundle_o.right = imm_i(instr_i[31:20]);
        bundle_o.imm   = imm_i(instr_i[31:20]);
        writes_rd      = 1'b1;
        case (funct3)
          F3_ADD:  bundle_o.op = ALU_ADD;
          F3_AND:  bundle_o.op = ALU_AND;
          F3_OR:   bundle_o.op = ALU_OR;
          default: legal = 1'b0;
        endcase
      end

      OPC_LOAD: begin
        bundle_o.left    = rs1_data_i;
        bundle_o.right   = imm_i(instr_i[31:20]);
        bundle_o.imm     = imm_i(instr_i[31:20]);
        bundle_o.is_load = 1'b1;
        writes_rd        = 1'b1;
        legal            = (funct3 == F3_WORD);
      end

      OPC_STORE: begin
        bundle_o.left       = rs1_data_i;
        bundle_o.right      = imm_s(instr_i[31:25], instr_i[11:7]);
        bundle_o.imm        = imm_s(instr_i[31:25], instr_i[11:7]);
        bundle_o.store_data = rs2_data_i;
        bundle_o.is_store   = 1'b1;
        legal               = (funct3 == F3_WORD);
      end

      OPC_BRANCH: begin
        bundle_o.op        = ALU_SUB;
        bundle_o.left      = rs1_data_i;
        bundle_o.right     = rs2_data_i;
        bundle_o.imm       = imm_b(instr_i[31:25], instr_i[11:7]);
        bundle_o.is_branch = 1'b1;
        legal              = (funct3 == F3_BEQ);
      end

      OPC_LUI: begin
        bundle_o.right = imm_u(instr_i[31:12]);
        bundle_o.imm   = imm_u(instr_i[31:12]);
        writes_rd      = 1'b1;
      end

      OPC_AUIPC: begin
        bundle_o.left  = pc_i;
        bundle_o.right = imm_u(instr_i[31:12]);
        bundle_o.imm   = imm_u(instr_i[31:12]);
        writes_rd      = 1'b1;
      end

      default: legal = 1'b0;
    endcase

    if (!legal) begin
      bundle_o         = BUNDLE_RESET;
      bundle_o.illegal = 1'b1;
    end else if (writes_rd && rd_field != 5'd0) begin
      bundle_o.rd        = rd_field;
      bundle_o.reg_write = 1'b1;
    end
  end

endmodule

// File: rtl/alu_issue.sv
// ID/EX issue slot in front of the ALU.  Decodes the incoming instruction and
// holds the result in a single registered slot with a valid/ready handshake.
// A flush empties the slot and drops whatever tried to enter alongside it;
// the counters record bundles actually handed to execute.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [31:0]      pc,
  input  logic [31:0]      rs1_data,
  input  logic [31:0]      rs2_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      left_operand,
  output logic [31:0]      right_operand,
  output alu_op_t          alu_op,
  output logic [31:0]      imm,
  output logic [31:0]      store_data,
  output logic [4:0]       rd,
  output logic             reg_write,
  output logic             is_branch,
  output logic             is_load,
  output logic             is_store,
  output logic             illegal,
  output logic [CNT_W-1:0] issued_cnt,
  output logic [CNT_W-1:0] illegal_cnt
);

  issue_bundle_t    decoded;
  issue_bundle_t    slot_q, slot_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic [CNT_W-1:0] illegal_q, illegal_d;
  logic             accept;
  logic             handshake;

  alu_ctrl_decode u_decode (
    .instr_i    (instr),
    .pc_i       (pc),
    .rs1_data_i (rs1_data),
    .rs2_data_i (rs2_data),
    .bundle_o   (decoded)
  );

  // The slot can take a new bundle whenever it is empty or being drained.
  assign in_ready  = !valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign handshake = valid_q && out_ready;

  // Next slot state: flush wins, then refill, then plain drain; data only
  // changes on a refill so a drained slot keeps showing its last bundle.
  always_comb begin
    valid_d   = valid_q;
    slot_d    = slot_q;
    issued_d  = issued_q;
    illegal_d = illegal_q;

    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      slot_d  = decoded;
    end else if (handshake) begin
      valid_d = 1'b0;
    end

    if (handshake) begin
      issued_d = issued_q + 1'b1;
      if (slot_q.illegal) begin
        illegal_d = illegal_q + 1'b1;
      end
    end
  end

  // Slot and counter registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      slot_q    <= BUNDLE_RESET;
      issued_q  <= '0;
      illegal_q <= '0;
    end else begin
      valid_q   <= valid_d;
      slot_q    <= slot_d;
      issued_q  <= issued_d;
      illegal_q <= illegal_d;
    end
  end

  assign out_valid     = valid_q;
  assign left_operand  = slot_q.left;
  assign right_operand = slot_q.right;
  assign alu_op        = slot_q.op;
  assign imm           = slot_q.imm;
  assign store_data    = slot_q.store_data;
  assign rd            = slot_q.rd;
  assign reg_write     = slot_q.reg_write;
  assign is_branch     = slot_q.is_branch;
  assign is_load       = slot_q.is_load;
  assign is_store      = slot_q.is_store;
  assign illegal       = slot_q.illegal;
  assign issued_cnt    = issued_q;
  assign illegal_cnt   = illegal_q;

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue.  The driver pushes the reference model's
// expected bundle whenever a bundle enters the slot; the monitor compares the
// slot against the queue head every cycle and retires it on consume or flush.
module tb_alu_issue;
  import alu_issue_pkg::*;

  localparam int CNT_W = 4;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] left;
    logic [31:0] right;
    logic [31:0] imm;
    logic [31:0] sdata;
    logic [4:0]  rd;
    logic        rw;
    logic        br;
    logic        ld;
    logic        st;
    logic        ill;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr;
  logic [31:0]      pc;
  logic [31:0]      rs1_data;
  logic [31:0]      rs2_data;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      left_operand;
  logic [31:0]      right_operand;
  alu_op_t          alu_op;
  logic [31:0]      imm;
  logic [31:0]      store_data;
  logic [4:0]       rd;
  logic             reg_write;
  logic             is_branch;
  logic             is_load;
  logic             is_store;
  logic             illegal;
  logic [CNT_W-1:0] issued_cnt;
  logic [CNT_W-1:0] illegal_cnt;

  int               checks = 0;
  int               errors = 0;
  bit               monitorOn = 0;
  exp_t             sbq[$];
  logic [CNT_W-1:0] mIssued = '0;
  logic [CNT_W-1:0] mIllegal = '0;

  alu_issue #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .instr         (instr),
    .pc            (pc),
    .rs1_data      (rs1_data),
    .rs2_data      (rs2_data),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .left_operand  (left_operand),
    .right_operand (right_operand),
    .alu_op        (alu_op),
    .imm           (imm),
    .store_data    (store_data),
    .rd            (rd),
    .reg_write     (reg_write),
    .is_branch     (is_branch),
    .is_load       (is_load),
    .is_store      (is_store),
    .illegal       (illegal),
    .issued_cnt    (issued_cnt),
    .illegal_cnt   (illegal_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Two's-complement value of the low 'bits' bits of v.
  function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
    int val;
    val = int'(v);
    if (val >= (1 << (bits - 1))) val = val - (1 << bits);
    return 32'(val);
  endfunction

  // Reference: expected bundle from the instruction rules, using arithmetic on fields.
  function automatic exp_t refModel(input logic [31:0] ins, input logic [31:0] pcv,
                                    input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rdf;
    logic [31:0] iI, sI, bI, uI;
    bit          ok;
    bit          wr;
    opc = ins[6:0];
    f3  = ins[14:12];
    f7  = ins[31:25];
    rdf = ins[11:7];
    iI  = sext(ins >> 20, 12);
    sI  = sext(32'(ins[31:25]) * 32 + 32'(ins[11:7]), 12);
    bI  = sext(32'(ins[31]) * 4096 + 32'(ins[7]) * 2048 + 32'(ins[30:25]) * 32 + 32'(ins[11:8]) * 2, 13);
    uI  = (ins >> 12) * 4096;
    e   = '{default: '0};
    e.op = ALU_ADD;
    ok  = 1;
    wr  = 0;
    case (opc)
      7'h33: begin
        e.left = a; e.right = b; wr = 1;
        if (f7 == 7'h00 && f3 == 3'd0) e.op = ALU_ADD;
        else if (f7 == 7'h20 && f3 == 3'd0) e.op = ALU_SUB;
        else if (f7 == 7'h00 && f3 == 3'd7) e.op = ALU_AND;
        else if (f7 == 7'h00 && f3 == 3'd6) e.op = ALU_OR;
        else ok = 0;
      end
      7'h13: begin
        e.left = a; e.right = iI; e.imm = iI; wr = 1;
        if (f3 == 3'd0) e.op = ALU_ADD;
        else if (f3 == 3'd7) e.op = ALU_AND;
        else if (f3 == 3'd6) e.op = ALU_OR;
        else ok = 0;
      end
      7'h03: begin
        ok = (f3 == 3'd2); e.left = a; e.right = iI; e.imm = iI; e.ld = 1; wr = 1;
      end
      7'h23: begin
        ok = (f3 == 3'd2); e.left = a; e.right = sI; e.imm = sI; e.st = 1; e.sdata = b;
      end
      7'h63: begin
        ok = (f3 == 3'd0); e.op = ALU_SUB; e.left = a; e.right = b; e.imm = bI; e.br = 1;
      end
      7'h37: begin
        e.right = uI; e.imm = uI; wr = 1;
      end
      7'h17: begin
        e.left = pcv; e.right = uI; e.imm = uI; wr = 1;
      end
      default: ok = 0;
    endcase
    if (!ok) begin
      e = '{default: '0};
      e.op = ALU_ADD;
      e.ill = 1;
    end else if (wr && rdf != 5'd0) begin
      e.rd = rdf;
      e.rw = 1;
    end
    return e;
  endfunction

  // Random instruction biased toward the supported encodings.
  function automatic logic [31:0] randInstr();
    logic [31:0] w;
    logic [6:0]  opcs [8];
    logic [2:0]  f3s  [4];
    opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h00};
    f3s  = '{3'd0, 3'd7, 3'd6, 3'd2};
    w = $urandom;
    if ($urandom_range(0, 7) != 0) w[6:0] = opcs[$urandom_range(0, 6)];
    if ($urandom_range(0, 3) != 0) w[14:12] = f3s[$urandom_range(0, 3)];
    if (w[6:0] == 7'h33 && $urandom_range(0, 3) != 0)
      w[31:25] = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
    if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
    return w;
  endfunction

  // One cycle of stimulus: drive, note acceptance mid-cycle, record at the edge.
  task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [31:0] pcv,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic rdy, input logic fl);
    exp_t e;
    bit   acc;
    in_valid  = v;
    instr     = ins;
    pc        = pcv;
    rs1_data  = a;
    rs2_data  = b;
    out_ready = rdy;
    flush     = fl;
    e = refModel(ins, pcv, a, b);
    @(negedge clk);
    acc = in_valid && in_ready && !flush;
    @(posedge clk);
    if (acc) sbq.push_back(e);
    #2;
  endtask

  // Monitor: compare the presented slot with the scoreboard head each cycle.
  always @(negedge clk) begin
    if (monitorOn) begin
      exp_t e;
      bit   expValid;
      expValid = (sbq.size() != 0);
      checkOutput("out_valid", {31'd0, out_valid}, {31'd0, expValid});
      checkOutput("in_ready", {31'd0, in_ready}, {31'd0, (!expValid || out_ready)});
      checkOutput("issued_cnt", 32'(issued_cnt), 32'(mIssued));
      checkOutput("illegal_cnt", 32'(illegal_cnt), 32'(mIllegal));
      if (expValid) begin
        e = sbq[0];
        checkOutput("alu_op", 32'(alu_op), 32'(e.op));
        checkOutput("left_operand", left_operand, e.left);
        checkOutput("right_operand", right_operand, e.right);
        checkOutput("imm", imm, e.imm);
        checkOutput("store_data", store_data, e.sdata);
        checkOutput("rd", 32'(rd), 32'(e.rd));
        checkOutput("flags", {27'd0, reg_write, is_branch, is_load, is_store, illegal},
                    {27'd0, e.rw, e.br, e.ld, e.st, e.ill});
        if (out_ready) begin
          mIssued = mIssued + 1'b1;
          if (e.ill) mIllegal = mIllegal + 1'b1;
        end
        if (out_ready || flush) void'(sbq.pop_front());
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    instr     = '0;
    pc        = '0;
    rs1_data  = '0;
    rs2_data  = '0;
    flush     = 1'b0;
    out_ready = 1'b0;

    #12;
    checkOutput("reset out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset alu_op", 32'(alu_op), 32'(ALU_ADD));
    checkOutput("reset issued_cnt", 32'(issued_cnt), 32'd0);
    checkOutput("reset left", left_operand, 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    monitorOn = 1;
    checkOutput("in_ready after reset", {31'd0, in_ready}, 32'd1);

    applyStimulus(1, 32'h002081B3, 32'h100, 32'd5, 32'd3, 1, 0);
    checkOutput("add left", left_operand, 32'd5);
    checkOutput("add right", right_operand, 32'd3);
    checkOutput("add rd", 32'(rd), 32'd3);
    checkOutput("add op", 32'(alu_op), 32'(ALU_ADD));
    checkOutput("add reg_write", {31'd0, reg_write}, 32'd1);
    applyStimulus(1, 32'h402081B3, 32'h104, 32'd5, 32'd3, 1, 0);
    checkOutput("sub op", 32'(alu_op), 32'(ALU_SUB));
    applyStimulus(1, 32'hFFF00293, 32'h108, 32'd0, 32'd9, 1, 0);
    checkOutput("addi right", right_operand, 32'hFFFFFFFF);
    checkOutput("addi rd", 32'(rd), 32'd5);
    applyStimulus(1, 32'h123453B7, 32'h10C, 32'd77, 32'd1, 1, 0);
    checkOutput("lui left", left_operand, 32'd0);
    checkOutput("lui right", right_operand, 32'h12345000);
    checkOutput("lui rd", 32'(rd), 32'd7);
    applyStimulus(1, 32'h00208463, 32'h110, 32'd7, 32'd7, 1, 0);
    checkOutput("beq branch", {31'd0, is_branch}, 32'd1);
    checkOutput("beq imm", imm, 32'd8);
    checkOutput("beq reg_write", {31'd0, reg_write}, 32'd0);
    applyStimulus(1, 32'h00000000, 32'h114, 32'd1, 32'd2, 1, 0);
    checkOutput("zero illegal", {31'd0, illegal}, 32'd1);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, randInstr(), $urandom, $urandom, $urandom, 0, 0);
      checkOutput("stall in_ready", {31'd0, in_ready}, 32'd0);
      checkOutput("stall illegal held", {31'd0, illegal}, 32'd1);
    end
    applyStimulus(1, 32'h00A00093, 32'h200, 32'd0, 32'd0, 1, 0);
    checkOutput("illegal_cnt after consume", 32'(illegal_cnt), 32'd1);
    for (int i = 0; i < 4; i++)
      applyStimulus(1, randInstr(), $urandom, $urandom, $urandom, 1, 0);

    applyStimulus(1, 32'h00100093, 32'h300, 32'd4, 32'd4, 1, 1);
    checkOutput("flush accept out_valid", {31'd0, out_valid}, 32'd0);
    applyStimulus(0, 32'h0, 32'h0, 32'd0, 32'd0, 1, 0);
    applyStimulus(1, 32'h00100093, 32'h304, 32'd4, 32'd4, 1, 0);
    applyStimulus(0, 32'h0, 32'h0, 32'd0, 32'd0, 0, 1);
    checkOutput("flush held out_valid", {31'd0, out_valid}, 32'd0);

    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 9) < 7, randInstr(), $urandom,
                    ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom, $urandom,
                    $urandom_range(0, 9) < 7, $urandom_range(0, 99) < 8);
    end
    applyStimulus(0, 32'h0, 32'h0, 32'd0, 32'd0, 1, 0);
    applyStimulus(0, 32'h0, 32'h0, 32'd0, 32'd0, 1, 0);

    applyStimulus(1, 32'h00500113, 32'h400, 32'd1, 32'd0, 0, 0);
    in_valid = 1'b0;
    #1;
    monitorOn = 0;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("midreset issued_cnt", 32'(issued_cnt), 32'd0);
    checkOutput("midreset illegal_cnt", 32'(illegal_cnt), 32'd0);
    checkOutput("midreset left", left_operand, 32'd0);
    sbq.delete();
    mIssued  = '0;
    mIllegal = '0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    monitorOn = 1;
    checkOutput("in_ready after midreset", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 17; i++)
      applyStimulus(1, 32'h00108093, 32'h500, $urandom, 32'd0, 1, 0);
    applyStimulus(0, 32'h0, 32'h0, 32'd0, 32'd0, 1, 0);
    checkOutput("issued_cnt wrap", 32'(issued_cnt), 32'd1);

    monitorOn = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
